// File: rtl/layer1_drain.sv
// layer1_drain: Layer-1 MAC array output collector.
// Captures NUM_MAC signed DW-bit column sums into a two-bank ping-pong
// buffer, with optional ReLU applied at capture. Drains the banks in
// capture order as a serial valid/ready word stream.
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   column, col_valid packed column sums and their one-cycle strobe
//   col_ready         at least one bank free (decoded from the full flags)
//   out_data/index/last/valid, out_ready  serial word stream
//   drop_err          sticky: a column arrived with both banks full
//   busy              any bank holds an undrained column
module layer1_drain #(
  parameter int unsigned NUM_MAC = 10,
  parameter int unsigned DW      = 16,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_MAC*DW-1:0] column,
  input  logic                  col_valid,
  output logic                  col_ready,
  output logic [DW-1:0]         out_data,
  output logic [3:0]            out_index,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  drop_err,
  output logic                  busy
);

  localparam int unsigned IW       = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MAC - 1);

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] bank [2][NUM_MAC];
  logic [DW-1:0] lane_val [NUM_MAC];
  logic [1:0]    full, full_nxt;
  logic          wr_ptr, wr_nxt;
  logic          rd_ptr, rd_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [DW-1:0] data_nxt;
  logic          last_nxt;
  logic          cap, drop, hs;

  assign col_ready = ~(full[0] & full[1]);
  assign busy      = full[0] | full[1];
  assign out_valid = (state == S_DRAIN);
  assign out_index = idx;

  assign cap  = col_valid & col_ready;
  assign drop = col_valid & ~col_ready;
  assign hs   = out_valid & out_ready;

  // Lane unpacking with optional ReLU sign clamp
  always_comb begin
    for (int i = 0; i < NUM_MAC; i++) begin
      lane_val[i] = column[DW*i +: DW];
      if (RELU_EN && column[DW*i + DW - 1]) lane_val[i] = '0;
    end
  end

  // Next-state, pointer, flag and output-word logic
  always_comb begin
    state_nxt = state;
    full_nxt  = full;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    idx_nxt   = idx;
    data_nxt  = '0;
    last_nxt  = 1'b0;

    if (cap) begin
      full_nxt[wr_ptr] = 1'b1;
      wr_nxt           = ~wr_ptr;
    end

    case (state)
      S_IDLE: begin
        idx_nxt = '0;
        // Same-edge capture counts so lane 0 appears the cycle after capture
        if (full[rd_ptr] || (cap && (wr_ptr == rd_ptr))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            idx_nxt          = '0;
            full_nxt[rd_ptr] = 1'b0;
            rd_nxt           = ~rd_ptr;
            state_nxt        = full_nxt[~rd_ptr] ? S_DRAIN : S_IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Bypass the capture path when the word to show is being written now
    if (state_nxt == S_DRAIN) begin
      if (cap && (wr_ptr == rd_nxt)) data_nxt = lane_val[idx_nxt];
      else                           data_nxt = bank[rd_nxt][idx_nxt];
      last_nxt = (idx_nxt == LAST_IDX);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      full     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      idx      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      drop_err <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_MAC; i++)
          bank[b][i] <= '0;
    end else begin
      state    <= state_nxt;
      full     <= full_nxt;
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      idx      <= idx_nxt;
      out_data <= data_nxt;
      out_last <= last_nxt;
      if (drop) drop_err <= 1'b1;
      if (cap)
        for (int i = 0; i < NUM_MAC; i++)
          bank[wr_ptr][i] <= lane_val[i];
    end
  end

endmodule

// File: tb/tb_layer1_drain.sv
// Testbench for layer1_drain: a ReLU instance and a pass-through instance
// share stimulus; a scoreboard of expected words per instance is filled at
// column strobe and consumed on each output handshake.
module tb_layer1_drain;

  localparam int unsigned NUM_MAC = 10;
  localparam int unsigned DW      = 16;
  localparam int unsigned CW      = NUM_MAC * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] column;
  logic          col_valid;
  logic          out_ready;

  logic          r_cready, r_last, r_valid, r_drop, r_busy;
  logic [DW-1:0] r_data;
  logic [3:0]    r_idx;
  logic          w_cready, w_last, w_valid, w_drop, w_busy;
  logic [DW-1:0] w_data;
  logic [3:0]    w_idx;

  layer1_drain #(.NUM_MAC(NUM_MAC), .DW(DW), .RELU_EN(1'b1)) u_relu (
    .clk(clk), .reset(reset), .column(column), .col_valid(col_valid),
    .col_ready(r_cready), .out_data(r_data), .out_index(r_idx),
    .out_last(r_last), .out_valid(r_valid), .out_ready(out_ready),
    .drop_err(r_drop), .busy(r_busy));

  layer1_drain #(.NUM_MAC(NUM_MAC), .DW(DW), .RELU_EN(1'b0)) u_raw (
    .clk(clk), .reset(reset), .column(column), .col_valid(col_valid),
    .col_ready(w_cready), .out_data(w_data), .out_index(w_idx),
    .out_last(w_last), .out_valid(w_valid), .out_ready(out_ready),
    .drop_err(w_drop), .busy(w_busy));

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cnt   = 0;     // columns the model holds
  bit          m_drop = 1'b0;
  int          words = 0;
  logic [20:0] q_relu [$];    // {last, index, data}
  logic [20:0] q_raw  [$];
  logic [20:0] e_r, e_w;
  logic [DW-1:0] lane;
  bit          acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      q_relu.delete();
      q_raw.delete();
      cnt    = 0;
      m_drop = 1'b0;
    end else begin
      check_eq("r_valid", 32'(r_valid), 32'(cnt > 0));
      check_eq("w_valid", 32'(w_valid), 32'(cnt > 0));
      check_eq("r_col_ready", 32'(r_cready), 32'(cnt < 2));
      check_eq("w_col_ready", 32'(w_cready), 32'(cnt < 2));
      check_eq("r_busy", 32'(r_busy), 32'(cnt > 0));
      check_eq("r_drop_err", 32'(r_drop), 32'(m_drop));
      check_eq("w_drop_err", 32'(w_drop), 32'(m_drop));
      acc = col_valid && (cnt < 2);
      if (col_valid && !acc) m_drop = 1'b1;
      if (r_valid && out_ready) begin
        if (q_relu.size() == 0) check_eq("r_unexpected_word", 32'd1, 32'd0);
        else begin
          e_r = q_relu.pop_front();
          check_eq("r_word", 32'({r_last, r_idx, r_data}), 32'(e_r));
          words++;
          if (e_r[20]) cnt--;
        end
      end
      if (w_valid && out_ready) begin
        if (q_raw.size() == 0) check_eq("w_unexpected_word", 32'd1, 32'd0);
        else begin
          e_w = q_raw.pop_front();
          check_eq("w_word", 32'({w_last, w_idx, w_data}), 32'(e_w));
        end
      end
      if (acc) begin
        for (int i = 0; i < NUM_MAC; i++) begin
          lane = column[DW*i +: DW];
          q_raw.push_back({(i == NUM_MAC - 1), 4'(i), lane});
          q_relu.push_back({(i == NUM_MAC - 1), 4'(i), lane[DW-1] ? 16'h0000 : lane});
        end
        cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_col();
    logic [CW-1:0] c;
    for (int i = 0; i < NUM_MAC; i++) c[DW*i +: DW] = DW'($urandom_range(0, 65535));
    return c;
  endfunction

  task automatic send_col(input logic [CW-1:0] c);
    column    = c;
    col_valid = 1'b1;
    tick();
    col_valid = 1'b0;
    column    = rand_col();
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((r_busy || w_busy) && n < max) begin
      tick();
      n++;
    end
    if (r_busy || w_busy) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_idx(input string tag, input logic [3:0] k, input int max);
    int n = 0;
    while (!(r_valid && r_idx == k) && n < max) begin
      tick();
      n++;
    end
    if (!(r_valid && r_idx == k)) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_valid"}, 32'({r_valid, w_valid}), 32'd0);
    check_eq({tag, "_data"}, 32'({r_data, w_data}), 32'd0);
    check_eq({tag, "_index"}, 32'({r_idx, w_idx}), 32'd0);
    check_eq({tag, "_last"}, 32'({r_last, w_last}), 32'd0);
    check_eq({tag, "_col_ready"}, 32'({r_cready, w_cready}), 32'd3);
    check_eq({tag, "_drop_err"}, 32'({r_drop, w_drop}), 32'd0);
    check_eq({tag, "_busy"}, 32'({r_busy, w_busy}), 32'd0);
  endtask

  logic [DW-1:0] t1 [NUM_MAC];
  logic [CW-1:0] c1;
  int            w0;

  initial begin
    t1 = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000,
           16'h1234, 16'hFF00, 16'h0010, 16'h0100, 16'h0ABC};
    for (int i = 0; i < NUM_MAC; i++) c1[DW*i +: DW] = t1[i];

    // Reset held with random inputs
    reset     = 1'b0;
    col_valid = 1'b0;
    out_ready = 1'b0;
    column    = '0;
    for (int k = 0; k < 4; k++) begin
      column    = rand_col();
      col_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      check_reset_vals("reset");
    end
    col_valid = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();

    // Single column, ReLU and pass-through side by side
    w0 = words;
    send_col(c1);
    wait_idle("t1_timeout", 40);
    check_eq("t1_words", 32'(words - w0), 32'd10);

    // Backpressure at lane 3
    send_col(rand_col());
    wait_idx("bp_timeout", 4'd3, 20);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("bp_valid", 32'(r_valid), 32'd1);
      check_eq("bp_index", 32'(r_idx), 32'd3);
      if (q_relu.size() > 0) check_eq("bp_data", 32'(r_data), 32'(q_relu[0][15:0]));
    end
    out_ready = 1'b1;
    wait_idle("bp_drain_timeout", 40);

    // Back-to-back columns
    w0 = words;
    send_col(rand_col());
    send_col(rand_col());
    wait_idle("b2b_timeout", 60);
    check_eq("b2b_words", 32'(words - w0), 32'd20);

    // Overflow: third column dropped
    out_ready = 1'b0;
    w0 = words;
    send_col(rand_col());
    send_col(rand_col());
    send_col(rand_col());
    check_eq("ovf_drop_err", 32'(r_drop), 32'd1);
    check_eq("ovf_col_ready", 32'(r_cready), 32'd0);
    repeat (3) tick();
    out_ready = 1'b1;
    wait_idle("ovf_timeout", 60);
    check_eq("ovf_words", 32'(words - w0), 32'd20);
    check_eq("ovf_drop_sticky", 32'(r_drop), 32'd1);

    // Random traffic with random backpressure
    for (int k = 0; k < 40; k++) begin
      column    = rand_col();
      col_valid = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    col_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand_timeout", 60);

    // Reset mid-drain at lane 5 with a second column buffered
    send_col(rand_col());
    send_col(rand_col());
    wait_idx("mid_timeout", 4'd5, 20);
    reset = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    w0 = words;
    send_col(rand_col());
    check_eq("post_index0", 32'(r_idx), 32'd0);
    wait_idle("post_timeout", 40);
    check_eq("post_words", 32'(words - w0), 32'd10);
    check_eq("post_drop_err", 32'(r_drop), 32'd0);
    check_eq("sb_empty", 32'(q_relu.size() + q_raw.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
